ws2812b_frame_receiver: RTL and testbench
=========================================

# ws2812b_frame_receiver

Serial-line decoder for the WS2812B single-wire LED protocol: the receiving end of the frame stream our LED driver emits on `leds_line`. It measures high-pulse widths on the line, rebuilds 24-bit GRB pixel words, and presents each pixel with its index and colour intensities. It detects the latch/reset gap and flags malformed traffic. It sits in the verification harness and in loop-back builds, tapped onto the LED line next to the driver, so frames can be checked on hardware without a physical strip.

## Interface
Parameters:
- `MAX_POS`, 109: number of pixels per frame; sets `pixel_index` width to `$clog2(MAX_POS)`.
- `BIT_THRESHOLD_CLK`, 30: high-pulse length, in clocks, at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- `MAX_HIGH_CLK`, 75: high-pulse length, in clocks, above which the pulse is a protocol error.
- `RESET_CLK_CNT`, 2500: low time, in clocks, that constitutes a latch/reset gap (50 us at 50 MHz).

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `leds_line`, input, 1: WS2812B serial data, asynchronous to `clk`.
- `pixel_valid`, output, 1: one-cycle pulse; a complete pixel is on the outputs below.
- `pixel_index`, output, `$clog2(MAX_POS)`: pixel position in the frame, starting at 0.
- `green_intensity`, output, 8: G byte, the first byte on the line.
- `red_intensity`, output, 8: R byte, the second byte on the line.
- `blue_intensity`, output, 8: B byte, the third byte on the line.
- `frame_done`, output, 1: one-cycle pulse on detection of a reset gap after at least one bit.
- `pixel_count`, output, `$clog2(MAX_POS+1)`: number of pixels received in the frame just closed; valid with `frame_done`.
- `error`, output, 1: sticky; cleared only by `rst` or at the next `frame_done`.

## Operation
- `leds_line` passes through a 2-flop synchronizer; all decoding uses the synchronized value `line_s`.
- The state machine has four states:
  - `WAIT_GAP`: entered from reset. Counts consecutive low cycles. At `RESET_CLK_CNT` it moves to `IDLE`. A high resets the count. No decoding occurs in this state, so a frame in progress at reset release is ignored.
  - `IDLE`: line is low, between frames. A rising edge moves to `HIGH` with `hcnt`=1.
  - `HIGH`: `hcnt` increments each cycle while the line is high.
    - On a falling edge, the bit is 1 if `hcnt` >= `BIT_THRESHOLD_CLK`, otherwise 0. The bit shifts into a 24-bit register, MSB first, and the state moves to `LOW` with `lcnt`=1.
    - If `hcnt` exceeds `MAX_HIGH_CLK`, set `error`, discard the partial word, and go to `WAIT_GAP`.
  - `LOW`: `lcnt` increments each cycle while the line is low. A rising edge moves to `HIGH`. When `lcnt` reaches `RESET_CLK_CNT`, the frame ends and the state moves to `IDLE`.
- Pixel assembly:
  - When the 24th bit shifts in, `pixel_valid` pulses. The outputs carry G = bits[23:16], R = [15:8], B = [7:0] and the current index, then the index increments.
  - The bit counter is 0..23 and wraps to 0 after each pixel.
- Frame end:
  - `frame_done` pulses and `pixel_count` is set to the index value.
  - The index and bit counter clear.
  - If the bit counter was non-zero (partial pixel), set `error` and drop the partial bits.
  - `error` clears on this `frame_done` unless the current frame set it.
- Overflow: pixels with index >= `MAX_POS` set `error`. `pixel_valid` is suppressed and the index saturates at `MAX_POS`.
- Data outputs hold their last value between pulses.
- Counters saturate; they never wrap.

## Timing
- Reset values: `pixel_valid`=0, `frame_done`=0, `error`=0, `pixel_index`=0, all intensities 0, `pixel_count`=0, state `WAIT_GAP`.
- Latency from a `leds_line` edge to its effect on state: 3 cycles (2 synchronizer stages plus 1 edge-detect register).
- `pixel_valid` is registered: it asserts exactly 1 cycle after the state machine sees the falling edge of the 24th bit.
- `frame_done` asserts 1 cycle after `lcnt` reaches `RESET_CLK_CNT`.
- `pixel_valid` and `frame_done` are never high in the same cycle.
- Pulse-width classification is exact at the boundaries:
  - `hcnt` = `BIT_THRESHOLD_CLK` - 1 decodes as 0.
  - `hcnt` = `BIT_THRESHOLD_CLK` decodes as 1.
  - `hcnt` = `MAX_HIGH_CLK` is legal; `MAX_HIGH_CLK` + 1 is an error.
- Asserting `rst` mid-frame returns to `WAIT_GAP` immediately and asynchronously. No `frame_done` is emitted.

## Structure
- Shared package `ws2812b_pkg` holds:
  - the state enum (`WAIT_GAP`, `IDLE`, `HIGH`, `LOW`);
  - the GRB byte-order constants (bit offsets 16/8/0);
  - default timing constants, shared with the driver so both ends agree.
- One natural sub-module: `line_synchronizer`, a 2-flop synchronizer plus rising/falling edge-detect outputs.
- Everything else stays in one module, roughly 200 lines.

## Test plan
- Reset release with a 2500-cycle low gap, then 1 pixel G=0xA5, R=0x3C, B=0xFF (high pulses of 20 and 40 cycles, 60-cycle bit period), then a gap. Required: `pixel_valid` once with index 0 and those bytes; `frame_done` with `pixel_count`=1; `error`=0.
- A full frame of 109 pixels where pixel n carries G=n, R=~n, B=n^0x55. Required: 109 `pixel_valid` pulses with matching index and data; `pixel_count`=109.
- Threshold sweep: high pulses of 29, 30, 75 and 76 cycles. Required: bits decode as 0, 1, 1, then `error` asserts and decoding stops until the next 2500-cycle gap.
- A frame of 12 bits followed by a gap. Required: no `pixel_valid`, `frame_done` with `pixel_count`=0, `error`=1. The next clean frame clears `error` at its `frame_done`.
- 110 pixels. Required: 109 pulses, then `error`=1 and `pixel_count` saturated at 109.
- `rst` pulsed during pixel 5, and line activity resumed mid-frame. Required: all outputs at reset values and no decode until a 2500-cycle low gap is seen.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver state encoding, GRB byte layout and
// the default line timing used by both the LED driver and this receiver.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

    // Bit offsets of each colour byte inside a 24-bit GRB pixel word.
    localparam int GRB_G_LSB = 16;
    localparam int GRB_R_LSB = 8;
    localparam int GRB_B_LSB = 0;

    // Default timing at 50 MHz.
    localparam int DEF_MAX_POS           = 109;
    localparam int DEF_BIT_THRESHOLD_CLK = 30;
    localparam int DEF_MAX_HIGH_CLK      = 75;
    localparam int DEF_RESET_CLK_CNT     = 2500;

    function automatic logic [7:0] grb_byte(input logic [23:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/ws2812b_frame_receiver_if.sv
// Decoded-pixel bus from the WS2812B receiver to whatever consumes frames.
interface ws2812b_frame_receiver_if
    import ws2812b_pkg::*;
#(
    parameter int MAX_POS = DEF_MAX_POS
);
    localparam int IDX_W = $clog2(MAX_POS);
    localparam int CNT_W = $clog2(MAX_POS + 1);

    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic [7:0]       green_intensity;
    logic [7:0]       red_intensity;
    logic [7:0]       blue_intensity;
    logic             frame_done;
    logic [CNT_W-1:0] pixel_count;
    logic             error;

    modport master (
        output pixel_valid, pixel_index, green_intensity, red_intensity,
               blue_intensity, frame_done, pixel_count, error
    );

    modport slave (
        input  pixel_valid, pixel_index, green_intensity, red_intensity,
               blue_intensity, frame_done, pixel_count, error
    );

endinterface

// File: rtl/line_synchronizer.sv
// Two-flop synchronizer for the asynchronous LED line, plus a third register
// that turns the synchronized level into single-cycle rise/fall strobes.
module line_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic line_s,
    output logic rise,
    output logic fall
);
    logic meta;
    logic line_d;

    // Synchronizer chain and edge-detect delay stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            line_s <= 1'b0;
            line_d <= 1'b0;
        end else begin
            meta   <= din;
            line_s <= meta;
            line_d <= line_s;
        end
    end

    assign rise = line_s & ~line_d;
    assign fall = ~line_s & line_d;

endmodule

// File: rtl/ws2812b_frame_receiver.sv
// WS2812B frame receiver: classifies high-pulse widths into bits, assembles
// 24-bit GRB pixels, detects the latch gap that closes a frame, and flags
// over-long pulses, partial pixels and pixel-count overflow.
module ws2812b_frame_receiver
    import ws2812b_pkg::*;
#(
    parameter int MAX_POS           = DEF_MAX_POS,
    parameter int BIT_THRESHOLD_CLK = DEF_BIT_THRESHOLD_CLK,
    parameter int MAX_HIGH_CLK      = DEF_MAX_HIGH_CLK,
    parameter int RESET_CLK_CNT     = DEF_RESET_CLK_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic leds_line,
    ws2812b_frame_receiver_if.master px
);
    localparam int IDX_W  = $clog2(MAX_POS);
    localparam int CNT_W  = $clog2(MAX_POS + 1);
    localparam int HCNT_W = $clog2(MAX_HIGH_CLK + 1);
    localparam int LCNT_W = $clog2(RESET_CLK_CNT + 1);
    localparam logic [4:0] LAST_BIT = 5'd23;

    logic line_s, rise, fall;

    line_synchronizer u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (leds_line),
        .line_s (line_s),
        .rise   (rise),
        .fall   (fall)
    );

    rx_state_t         state, next_state;
    logic [HCNT_W-1:0] hcnt;
    logic [LCNT_W-1:0] lcnt;
    logic [22:0]       shreg;
    logic [4:0]        bitcnt;
    logic [CNT_W-1:0]  idx;        // may reach MAX_POS, hence the wider type
    logic              err_frame;  // an error was raised inside the open frame

    logic              pixel_valid_q, frame_done_q, error_q;
    logic [IDX_W-1:0]  index_q;
    logic [7:0]        green_q, red_q, blue_q;
    logic [CNT_W-1:0]  count_q;

    logic        bit_val, bit_done, word_done, overrun, gap_seen, frame_end, idx_full;
    logic [23:0] word;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= WAIT_GAP;
        else     state <= next_state;
    end

    // Next-state decision from the decode strobes.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            WAIT_GAP: if (gap_seen) next_state = IDLE;
            IDLE:     if (rise)     next_state = HIGH;
            HIGH: begin
                if (bit_done)     next_state = LOW;
                else if (overrun) next_state = WAIT_GAP;
            end
            LOW: begin
                if (rise)           next_state = HIGH;
                else if (frame_end) next_state = IDLE;
            end
            default: next_state = WAIT_GAP;
        endcase
    end

    // Decode strobes: bit value, bit/word completion, overrun and gap detection.
    always_comb begin
        bit_val   = hcnt >= HCNT_W'(BIT_THRESHOLD_CLK);
        word      = {shreg, bit_val};
        bit_done  = (state == HIGH) && fall;
        word_done = bit_done && (bitcnt == LAST_BIT);
        overrun   = (state == HIGH) && !fall && (hcnt >= HCNT_W'(MAX_HIGH_CLK));
        gap_seen  = (state == WAIT_GAP) && (lcnt == LCNT_W'(RESET_CLK_CNT));
        frame_end = (state == LOW) && !rise && (lcnt == LCNT_W'(RESET_CLK_CNT));
        idx_full  = idx >= CNT_W'(MAX_POS);
    end

    // Pulse counters, bit shifting, pixel emission and frame bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too, because the outputs must read zero straight out of reset.
        if (rst) begin
            hcnt          <= '0;
            lcnt          <= '0;
            shreg         <= '0;
            bitcnt        <= '0;
            idx           <= '0;
            err_frame     <= 1'b0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            index_q       <= '0;
            green_q       <= '0;
            red_q         <= '0;
            blue_q        <= '0;
            count_q       <= '0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state)
                WAIT_GAP: begin
                    if (line_s)         lcnt <= '0;
                    else if (!gap_seen) lcnt <= lcnt + 1'b1;
                end
                IDLE: if (rise) hcnt <= HCNT_W'(1);
                HIGH: begin
                    if (bit_done) begin
                        lcnt  <= LCNT_W'(1);
                        shreg <= word[22:0];
                        if (word_done) begin
                            bitcnt <= '0;
                            if (idx_full) begin
                                error_q   <= 1'b1;
                                err_frame <= 1'b1;
                            end else begin
                                pixel_valid_q <= 1'b1;
                                index_q       <= idx[IDX_W-1:0];
                                green_q       <= grb_byte(word, GRB_G_LSB);
                                red_q         <= grb_byte(word, GRB_R_LSB);
                                blue_q        <= grb_byte(word, GRB_B_LSB);
                                idx           <= idx + 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else if (overrun) begin
                        // Abandon the frame; the next one starts clean after a gap.
                        error_q   <= 1'b1;
                        err_frame <= 1'b0;
                        shreg     <= '0;
                        bitcnt    <= '0;
                        idx       <= '0;
                        lcnt      <= '0;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        hcnt <= HCNT_W'(1);
                    end else if (frame_end) begin
                        frame_done_q <= 1'b1;
                        count_q      <= idx;
                        idx          <= '0;
                        bitcnt       <= '0;
                        shreg        <= '0;
                        error_q      <= err_frame || (bitcnt != '0);
                        err_frame    <= 1'b0;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign px.pixel_valid     = pixel_valid_q;
    assign px.pixel_index     = index_q;
    assign px.green_intensity = green_q;
    assign px.red_intensity   = red_q;
    assign px.blue_intensity  = blue_q;
    assign px.frame_done      = frame_done_q;
    assign px.pixel_count     = count_q;
    assign px.error           = error_q;

endmodule

// File: tb/tb_ws2812b_frame_receiver.sv
// Directed bench for the WS2812B frame receiver: drives pulse trains on the
// LED line, records every pixel/frame event, and compares against
// hand-computed expectations.
module tb_ws2812b_frame_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic leds_line = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    ws2812b_frame_receiver_if #(.MAX_POS(109)) px ();

    ws2812b_frame_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .leds_line (leds_line),
        .px        (px)
    );

    always #5 clk = ~clk;

    // Event recorder, sampled mid-cycle.
    logic [30:0] pix_q[$];
    int fd_cnt = 0;
    int fd_count = -1;
    int fd_err = -1;
    int both_seen = 0;

    always @(negedge clk) begin
        if (px.pixel_valid)
            pix_q.push_back({px.pixel_index, px.green_intensity, px.red_intensity, px.blue_intensity});
        if (px.frame_done) begin
            fd_cnt   = fd_cnt + 1;
            fd_count = int'(px.pixel_count);
            fd_err   = int'(px.error);
        end
        if (px.pixel_valid && px.frame_done) both_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        return (i < pix_q.size()) ? {1'b0, pix_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pix(input int idx, input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        return {1'b0, 7'(idx), g, r, b};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(px.pixel_valid), 32'd0);
        check({tag, "_done"},  32'(px.frame_done), 32'd0);
        check({tag, "_error"}, 32'(px.error), 32'd0);
        check({tag, "_index"}, 32'(px.pixel_index), 32'd0);
        check({tag, "_grb"},   {8'd0, px.green_intensity, px.red_intensity, px.blue_intensity}, 32'd0);
        check({tag, "_count"}, 32'(px.pixel_count), 32'd0);
    endtask

    // Line drivers; every task starts and ends 1 time unit after a rising edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        leds_line = 1'b1;
        hold(hi);
        leds_line = 1'b0;
        hold(lo);
    endtask

    task automatic send_bit(input bit b, input bit slow);
        if (slow) pulse(b ? 40 : 20, b ? 20 : 40);
        else      pulse(b ? 30 : 2, 1);
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits, input bit slow);
        for (int i = 23; i > 23 - nbits; i--) send_bit(w[i], slow);
    endtask

    task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b, input bit slow);
        send_word({g, r, b}, 24, slow);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] g;
        @(posedge clk);
        #1;
        hold(3);
        check_reset_values("reset");
        rst = 1'b0;

        // Single slow pixel after the initial gap.
        hold(2600);
        send_pixel(8'hA5, 8'h3C, 8'hFF, 1'b1);
        hold(2600);
        check("p1_num_pixels", 32'(pix_q.size()), 32'd1);
        check("p1_pixel", q_at(0), pix(0, 8'hA5, 8'h3C, 8'hFF));
        check("p1_frames", 32'(fd_cnt), 32'd1);
        check("p1_count", 32'(fd_count), 32'd1);
        check("p1_error", 32'(fd_err), 32'd0);
        check("p1_hold", {8'd0, px.green_intensity, px.red_intensity, px.blue_intensity}, 32'h00A53CFF);

        // Full 109-pixel frame.
        pix_q.delete();
        for (int n = 0; n < 109; n++) begin
            g = 8'(n);
            send_pixel(g, ~g, g ^ 8'h55, 1'b0);
        end
        hold(2600);
        check("full_num_pixels", 32'(pix_q.size()), 32'd109);
        for (int n = 0; n < 109; n++) begin
            g = 8'(n);
            check($sformatf("full_px%0d", n), q_at(n), pix(n, g, ~g, g ^ 8'h55));
        end
        check("full_frames", 32'(fd_cnt), 32'd2);
        check("full_count", 32'(fd_count), 32'd109);
        check("full_error", 32'(fd_err), 32'd0);

        // Threshold sweep: 21 zeros then 29/30/75 give B=0x03; 76 is an error.
        pix_q.delete();
        send_word(24'h0, 21, 1'b0);
        pulse(29, 10);
        pulse(30, 10);
        pulse(75, 10);
        check("sweep_num_pixels", 32'(pix_q.size()), 32'd1);
        check("sweep_pixel", q_at(0), pix(0, 8'h00, 8'h00, 8'h03));
        check("sweep_error_before", 32'(px.error), 32'd0);
        pulse(76, 10);
        hold(5);
        check("sweep_error_after", 32'(px.error), 32'd1);
        send_word(24'hFFFFFF, 24, 1'b0);
        hold(20);
        check("sweep_no_decode", 32'(pix_q.size()), 32'd1);
        hold(2600);
        check("sweep_no_frame", 32'(fd_cnt), 32'd2);
        check("sweep_error_sticky", 32'(px.error), 32'd1);

        // 12-bit partial frame, then a clean frame that clears the error.
        send_word(24'hABC000, 12, 1'b0);
        hold(2600);
        check("part_num_pixels", 32'(pix_q.size()), 32'd1);
        check("part_frames", 32'(fd_cnt), 32'd3);
        check("part_count", 32'(fd_count), 32'd0);
        check("part_error", 32'(fd_err), 32'd1);
        send_pixel(8'h12, 8'h34, 8'h56, 1'b0);
        hold(2600);
        check("clean_pixel", q_at(1), pix(0, 8'h12, 8'h34, 8'h56));
        check("clean_frames", 32'(fd_cnt), 32'd4);
        check("clean_count", 32'(fd_count), 32'd1);
        check("clean_error", 32'(px.error), 32'd0);

        // 110 pixels: one too many.
        pix_q.delete();
        for (int n = 0; n < 110; n++) send_pixel(8'h00, 8'h00, 8'h00, 1'b0);
        hold(2600);
        check("ovf_num_pixels", 32'(pix_q.size()), 32'd109);
        check("ovf_last_pixel", q_at(108), pix(108, 8'h00, 8'h00, 8'h00));
        check("ovf_frames", 32'(fd_cnt), 32'd5);
        check("ovf_count", 32'(fd_count), 32'd109);
        check("ovf_error", 32'(fd_err), 32'd1);
        check("ovf_index_hold", 32'(px.pixel_index), 32'd108);

        // Reset during pixel 5, with traffic continuing afterwards.
        pix_q.delete();
        for (int n = 0; n < 5; n++) send_pixel(8'h00, 8'h00, 8'h00, 1'b0);
        send_word(24'hFFFFFF, 10, 1'b0);
        check("rstmid_num_pixels", 32'(pix_q.size()), 32'd5);
        rst = 1'b1;
        #2;
        check_reset_values("rst_async");
        hold(3);
        rst = 1'b0;
        send_word(24'hFFFFFF, 14, 1'b0);
        for (int n = 0; n < 3; n++) send_pixel(8'hFF, 8'h0F, 8'hF0, 1'b0);
        hold(20);
        check("rstmid_no_decode", 32'(pix_q.size()), 32'd5);
        check_reset_values("rst_after_traffic");
        hold(2600);
        check("rstmid_no_frame", 32'(fd_cnt), 32'd5);
        send_pixel(8'h5A, 8'hC3, 8'h81, 1'b0);
        hold(2600);
        check("rstmid_pixel", q_at(5), pix(0, 8'h5A, 8'hC3, 8'h81));
        check("rstmid_frames", 32'(fd_cnt), 32'd6);
        check("rstmid_count", 32'(fd_count), 32'd1);
        check("rstmid_error", 32'(fd_err), 32'd0);

        check("valid_done_overlap", 32'(both_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
